// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory address/data, redirect
// request from the branch unit, and the valid/ready instruction stream to decode.
//   master : fetch controller side (drives imem_addr and the instr_* stream)
//   slave  : environment side (memory, branch unit, decode)
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc,
    input  imem_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc,
    output imem_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// PC sequencer / fetch controller. Issues word-aligned fetches to a memory with
// one-cycle registered read latency, queues responses in a 2-entry buffer and
// presents them to decode over valid/ready. A redirect flushes the buffer,
// squashes the in-flight response and restarts fetch at the target.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          instr_fetch_ctrl_if.master (imem_addr/imem_data,
//                redirect_valid/redirect_pc, instr_valid/instr_ready/instr/instr_pc)
//   fetch_fault  sticky out-of-range fetch flag (only with FETCH_BOUND_CHECK_EN)
//
// Build option: define FETCH_BOUND_CHECK_EN to replace responses from
// PC >= MEM_SIZE*4 with a NOP and raise fetch_fault.
module instr_fetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic clk,
  input  logic rst,
`ifdef FETCH_BOUND_CHECK_EN
  output logic fetch_fault,
`endif
  instr_fetch_ctrl_if.master bus
);

  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FULL     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];
  logic                  head_q;
  logic [1:0]            count_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  tail;
  logic [1:0]            occupancy;
  logic [1:0]            count_d;
  logic [DATA_WIDTH-1:0] push_data;

  // Decode-facing stream; a redirect kills the handshake in its own cycle.
  assign bus.instr_valid = (count_q != 2'd0) && !bus.redirect_valid;
  assign bus.instr       = buf_data_q[head_q];
  assign bus.instr_pc    = buf_pc_q[head_q];
  assign bus.imem_addr   = fetch_pc_q;

  assign pop  = bus.instr_valid && bus.instr_ready;
  assign tail = head_q ^ count_q[0];

  // Buffered + in-flight instructions left after this cycle's pop; the
  // issue rule keeps this at most 2 so the buffer cannot overflow.
  assign occupancy = count_q - 2'(pop) + 2'(inflight_q);
  assign count_d   = bus.redirect_valid ? 2'd0 : occupancy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect has priority in every state.
  always_comb begin
    state_d = S_RUN;
    if (bus.redirect_valid) begin
      state_d = S_REDIRECT;
    end else if (count_d == 2'd2) begin
      state_d = S_FULL;
    end
  end

  // FSM outputs: fetch issue and response push.
  always_comb begin
    issue = 1'b0;
    push  = inflight_q && !bus.redirect_valid;
    case (state_q)
      S_REDIRECT:    issue = !bus.redirect_valid;
      S_RUN, S_FULL: issue = !bus.redirect_valid && (occupancy < 2'd2);
      default:       issue = 1'b0;
    endcase
  end

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] BOUND_ADDR = ADDR_WIDTH'(MEM_SIZE * 4);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);

  logic oob;
  assign oob       = inflight_pc_q >= BOUND_ADDR;
  assign push_data = oob ? NOP_INSTR : bus.imem_data;

  // Sticky fault; only a response that actually lands in the buffer counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (push && oob) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign push_data = bus.imem_data;

  logic [31:0] unused_mem_size;
  assign unused_mem_size = 32'(MEM_SIZE);
`endif

  // Low target bits are discarded to keep fetches word-aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // PC sequencing, in-flight tracking and the response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= 1'b0;
      count_q       <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (bus.redirect_valid) begin
        fetch_pc_q <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        inflight_q <= 1'b0;
        head_q     <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          inflight_pc_q <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + ADDR_WIDTH'(4);
        end
        if (push) begin
          buf_data_q[tail] <= push_data;
          buf_pc_q[tail]   <= inflight_pc_q;
        end
        if (pop) begin
          head_q <= ~head_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed vector table, hand-written
// stall / reset / wrap / bound sequences, then randomized traffic checked by a
// stream-level reference model.
module tb_instr_fetch_ctrl;

  logic clk;
  logic rst;
`ifdef FETCH_BOUND_CHECK_EN
  logic fetch_fault;
`endif

  instr_fetch_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  instr_fetch_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_BOUND_CHECK_EN
    .fetch_fault(fetch_fault),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] aa;
    aa = {a[31:2], 2'b00};
    case (aa)
      32'h00: return 32'h00500093;
      32'h04: return 32'h00600113;
      32'h08: return 32'h002081b3;
      32'h0C: return 32'h40208233;
      32'h10: return 32'h00418293;
      32'h14: return 32'h00128313;
      32'h18: return 32'h006303b3;
      32'h1C: return 32'h0020a4b3;
      32'hFFC: return 32'h00000013;
      default: return aa ^ 32'h13579BDF;
    endcase
  endfunction

  // Instruction decode should see for a given PC.
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
`ifdef FETCH_BOUND_CHECK_EN
    if (pc >= 32'd4096) return 32'h00000013;
`endif
    return mem_word(pc);
  endfunction

  // One-cycle registered-read memory.
  always @(posedge clk) bus.imem_data <= mem_word(bus.imem_addr);

  // Reference model: after a restart (reset release or redirect cycle) the
  // stream is empty for two cycles and then never runs dry; every delivered
  // instruction is the next sequential PC from the restart target.
  int          since   = -1;
  logic [31:0] exp_pc  = 32'h0;
  logic        prev_fault = 1'b0;

  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        since      = -1;
        exp_pc     = 32'h0;
        prev_fault = 1'b0;
      end else begin
        if (since < 1000) since++;
        exp_v = (since >= 2) && !bus.redirect_valid;
        check("mon_valid", 32'(bus.instr_valid), 32'(exp_v));
        check("mon_align", 32'(bus.imem_addr[1:0]), 32'h0);
        if (exp_v) begin
          check("mon_pc", bus.instr_pc, exp_pc);
          check("mon_instr", bus.instr, exp_instr(exp_pc));
`ifdef FETCH_BOUND_CHECK_EN
          if (exp_pc >= 32'd4096) check("mon_fault_oob", 32'(fetch_fault), 32'h1);
`endif
          if (bus.instr_ready) exp_pc = exp_pc + 32'd4;
        end
`ifdef FETCH_BOUND_CHECK_EN
        if (prev_fault) check("mon_fault_sticky", 32'(fetch_fault), 32'h1);
        prev_fault = fetch_fault;
`endif
        if (bus.redirect_valid) begin
          since  = -1;
          exp_pc = {bus.redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into cycle 0 after reset release.
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_pcs [3];
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    // Streaming from reset, then a misaligned redirect to 0x1F.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'h04};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h00500093, 32'h08};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h00600113, 32'h0C};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h002081b3, 32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h40208233, 32'h14};
    vecs[6]  = '{1'b1, 1'b1, 32'h1F, 1'b0, 32'h00, 32'h0,        32'h18};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'h1C};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'h20};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 32'h0020a4b3, 32'h24};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'h13579BFF, 32'h28};

    do_reset();
    check("reset_instr", bus.instr, 32'h0);
    check("reset_instr_pc", bus.instr_pc, 32'h0);
`ifdef FETCH_BOUND_CHECK_EN
    check("reset_fault", 32'(fetch_fault), 32'h0);
`endif
    for (int i = 0; i < 11; i++) begin
      bus.instr_ready    = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
      end
      tick();
    end
    bus.redirect_valid = 1'b0;

    // Backpressure: stall five cycles on the first instruction.
    do_reset();
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.instr_valid), 32'h1);
      check("stall_pc", bus.instr_pc, 32'h0);
      check("stall_instr", bus.instr, 32'h00500093);
      check("stall_addr", bus.imem_addr, 32'h08);
      tick();
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("unstall_pc", bus.instr_pc, 32'(i * 4));
      tick();
    end

    // Reset while the buffer holds an instruction and another is in flight.
    bus.instr_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.instr_valid), 32'(i == 2));
      if (i == 2) check("rst_mid_pc", bus.instr_pc, 32'h0);
      tick();
    end

`ifdef FETCH_BOUND_CHECK_EN
    // Crossing the end of memory: last word is real data, next one faults.
    do_reset();
    bus.instr_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0FFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("bound_pc_ffc", bus.instr_pc, 32'h0FFC);
    check("bound_instr_ffc", bus.instr, 32'h00000013);
    check("bound_fault_before", 32'(fetch_fault), 32'h0);
    tick();
    @(negedge clk);
    check("bound_pc_1000", bus.instr_pc, 32'h1000);
    check("bound_instr_1000", bus.instr, 32'h00000013);
    check("bound_fault_set", 32'(fetch_fault), 32'h1);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("bound_fault_held", 32'(fetch_fault), 32'h1);
    do_reset();
    @(negedge clk);
    check("bound_fault_cleared", 32'(fetch_fault), 32'h0);
    tick();
`endif

    // Redirect to the top word: PC must wrap to zero.
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    wrap_pcs[0] = 32'hFFFF_FFFC;
    wrap_pcs[1] = 32'h0000_0000;
    wrap_pcs[2] = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wrap_valid", 32'(bus.instr_valid), 32'h1);
      check("wrap_pc", bus.instr_pc, wrap_pcs[i]);
      tick();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int sel;
      rst = ($urandom_range(0, 199) == 0);
      bus.instr_ready    = ($urandom_range(0, 99) < 70);
      bus.redirect_valid = ($urandom_range(0, 99) < 4);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0, 1:    bus.redirect_pc = $urandom_range(0, 255);
        2:       bus.redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: bus.redirect_pc = $urandom;
      endcase
      tick();
    end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
